lc3_trace_recorder: RTL
=======================

// Module: lc3_trace_recorder
// PURPOSE
//  Synthesizable, parametrised instruction-trace recorder for the lc3 core; replaces file-based trace dumping.
//  - Watches the core's debug taps and builds one PennSim-style record per retired instruction:
//    PC-1, IR, reg-write flag/value, mem-write flag/addr/data.
//  - Stores records in a circular buffer and drains them over a valid/ready port (UART/JTAG bridge or bench).
//  - Adds overwrite/stop modes, halt detection and overflow reporting.
// PARAMETERS
//  DEPTH        16      record slots; power of 2, >=2
//  WRAP_MODE    0       0 = stop-when-full (drop new), 1 = overwrite oldest
//  SKIP_ZERO    1       1 = do not record IR==16'h0000 (NOP/BR-never)
//  FETCH_STATE  6'd18   FSM encoding of the FETCH state
//  HALT_WORD    16'hFFFF  IR value that freezes capture
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  clear        in   1   sync flush of buffer, flags, accumulators (not halt config)
//  cur_state    in   6   core FSM current state
//  pc           in   16  core PC (already incremented during fetch)
//  instruction  in   16  core IR
//  databus      in   16  core data bus
//  ldreg        in   1   regfile write enable
//  mar          in   16  MAR value
//  mdr          in   16  MDR value
//  rw           in   1   memory write strobe
//  rd_valid     out  1   record available at rd_data
//  rd_ready     in   1   consumer accepts rd_data
//  rd_data      out  82  {pc_m1,ir,reg_we,reg_val,mem_we,mem_addr,mem_data}
//  count        out  $clog2(DEPTH)+1  records held
//  overflow     out  1   sticky: a record was dropped (mode 0) or overwritten (mode 1)
//  halted       out  1   sticky: HALT_WORD seen; capture frozen
// BEHAVIOUR
//  Reset/clear: buffer empty, count=0, rd_valid=0, overflow=0, halted=0, accumulators=0, armed=0.
//    rd_data is don't-care while rd_valid=0.
//  Accumulate (every cycle, capture not frozen):
//    - ldreg=1   -> reg_we=1, reg_val=databus (last write wins)
//    - rw=1      -> mem_we=1, mem_addr=mar, mem_data=mdr (last wins)
//  Commit point: cycle where cur_state==FETCH_STATE and the previous cycle's cur_state != FETCH_STATE.
//    - armed=0 (first fetch after reset/clear): set armed, discard accumulators, no push.
//    - armed=1: push {pc-16'd1, instruction, accumulators}, unless SKIP_ZERO && instruction==0.
//    - At a commit point, accumulators are cleared; that same cycle's ldreg/rw belong to the next instruction.
//    - pc/instruction at the commit cycle still describe the retiring instruction.
//  Halt: instruction==HALT_WORD at any cycle -> halted=1.
//    - The HALT record itself is not pushed; no further pushes until reset/clear.
//    - Readout continues while halted.
//  Push timing: a record pushed in cycle N is visible on rd_data with rd_valid=1 in cycle N+1.
//  Pop: on rd_valid && rd_ready, rd_data advances to the next record in the following cycle.
//  Full, WRAP_MODE=0:
//    - push with no pop: dropped, overflow=1, count stays DEPTH.
//    - push with pop in the same cycle: both accepted, count stays DEPTH.
//  Full, WRAP_MODE=1:
//    - push with no pop: oldest overwritten, rd pointer advances, overflow=1, count=DEPTH.
//    - push with pop: both accepted, no overflow.
//  Empty with pop requested: no effect.
//  Empty with simultaneous push: record appears the next cycle; it is not bypassed combinationally.
//  Pointers are log2(DEPTH) bits and wrap naturally; count is saturating-free (0..DEPTH).
//  Reset or clear mid-readout: immediate flush; rd_valid=0 in the following cycle.
// STRUCTURE
//  Shared package/include lc3_trace_pkg:
//    - trace_rec_t field layout and widths (REC_W=82)
//    - FETCH_STATE and HALT_WORD constants, shared with the core FSM
//  Sub-module trace_fifo #(W,DEPTH,WRAP_MODE):
//    - circular buffer, wr/rd pointers, count, overflow
//  Top level: fetch-edge detect, armed/halted flags, accumulators, record packing.
// TESTING
//  1. Reset, drive FETCH then ADD with ldreg=1, databus=16'h0007, pc=16'h3001, IR=16'h1021, then FETCH
//     -> one record {3000,1021,1,0007,0,0000,0000}, rd_valid the next cycle.
//  2. STR sequence: rw=1, mar=16'h4000, mdr=16'hBEEF, then FETCH
//     -> record mem_we=1, addr 4000, data BEEF, reg_we=0.
//  3. DEPTH=4, WRAP_MODE=0, push 6 records with rd_ready=0
//     -> count=4, overflow=1, reads return records 1-4.
//  4. DEPTH=4, WRAP_MODE=1, push 6 records
//     -> count=4, overflow=1, reads return records 3-6 in order.
//  5. IR=16'hFFFF after 2 records
//     -> halted=1, no further pushes; both records still drain; clear restores empty.
//  6. Full buffer with simultaneous push+pop each cycle for 8 cycles
//     -> count stays 4, no overflow, order preserved.

Source files
------------

// File: rtl/lc3_trace_pkg.sv
// Shared definitions for the lc3 instruction-trace recorder: record layout,
// core FSM constants and capture-state encoding.
package lc3_trace_pkg;

    localparam int unsigned REC_W = 82;

    localparam logic [5:0]  FETCH_STATE = 6'd18;
    localparam logic [15:0] HALT_WORD   = 16'hFFFF;

    typedef struct packed {
        logic [15:0] pc_m1;
        logic [15:0] ir;
        logic        reg_we;
        logic [15:0] reg_val;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_ARMED,
        CAP_HALTED
    } cap_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer with stop-when-full or overwrite-oldest policy,
// occupancy count and sticky overflow flag.
module trace_fifo #(
    parameter int unsigned W         = 82,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic full;
    logic empty;
    logic do_pop;
    logic accept;
    logic evict;
    logic drop;
    logic write;

    always_comb begin
        full   = (count == FULL_CNT);
        empty  = (count == '0);
        do_pop = pop && !empty;
        accept = push && (!full || do_pop);
        // full with no pop: overwrite the oldest slot or discard the new record
        evict  = push && full && !do_pop && (WRAP_MODE != 0);
        drop   = push && full && !do_pop && (WRAP_MODE == 0);
        write  = accept || evict;
    end

    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || evict) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !accept) begin
                count <= count - 1'b1;
            end
            if (evict || drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign valid = !empty;
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/lc3_trace_recorder.sv
// Builds one trace record per retired lc3 instruction from the core debug taps
// and queues it for readout over a valid/ready port.
module lc3_trace_recorder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WRAP_MODE   = 0,
    parameter int unsigned SKIP_ZERO   = 1,
    parameter logic [5:0]  FETCH_STATE = lc3_trace_pkg::FETCH_STATE,
    parameter logic [15:0] HALT_WORD   = lc3_trace_pkg::HALT_WORD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [5:0]               cur_state,
    input  logic [15:0]              pc,
    input  logic [15:0]              instruction,
    input  logic [15:0]              databus,
    input  logic                     ldreg,
    input  logic [15:0]              mar,
    input  logic [15:0]              mdr,
    input  logic                     rw,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [81:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted
);

    import lc3_trace_pkg::*;

    cap_state_t  cap_state;
    logic        fetch_q;
    logic        acc_reg_we;
    logic [15:0] acc_reg_val;
    logic        acc_mem_we;
    logic [15:0] acc_mem_addr;
    logic [15:0] acc_mem_data;

    logic       in_fetch;
    logic       commit;
    logic       halt_seen;
    logic       frozen;
    logic       push;
    trace_rec_t rec;

    always_comb begin
        in_fetch  = (cur_state == FETCH_STATE);
        commit    = in_fetch && !fetch_q;
        halt_seen = (instruction == HALT_WORD);
        frozen    = (cap_state == CAP_HALTED);
        push      = commit && (cap_state == CAP_ARMED) && !halt_seen &&
                    !((SKIP_ZERO != 0) && (instruction == '0));
        rec          = '0;
        rec.pc_m1    = pc - 16'd1;
        rec.ir       = instruction;
        rec.reg_we   = acc_reg_we;
        rec.reg_val  = acc_reg_val;
        rec.mem_we   = acc_mem_we;
        rec.mem_addr = acc_mem_addr;
        rec.mem_data = acc_mem_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_q      <= 1'b0;
            cap_state    <= CAP_IDLE;
            acc_reg_we   <= 1'b0;
            acc_reg_val  <= '0;
            acc_mem_we   <= 1'b0;
            acc_mem_addr <= '0;
            acc_mem_data <= '0;
        end else begin
            fetch_q <= in_fetch;
            if (clear) begin
                cap_state    <= CAP_IDLE;
                acc_reg_we   <= 1'b0;
                acc_reg_val  <= '0;
                acc_mem_we   <= 1'b0;
                acc_mem_addr <= '0;
                acc_mem_data <= '0;
            end else begin
                if (halt_seen) begin
                    cap_state <= CAP_HALTED;
                end else if (commit && (cap_state == CAP_IDLE)) begin
                    cap_state <= CAP_ARMED;
                end
                if (!frozen) begin
                    // later assignments win, so commit-cycle writes seed the next record
                    if (commit) begin
                        acc_reg_we   <= 1'b0;
                        acc_reg_val  <= '0;
                        acc_mem_we   <= 1'b0;
                        acc_mem_addr <= '0;
                        acc_mem_data <= '0;
                    end
                    if (ldreg) begin
                        acc_reg_we  <= 1'b1;
                        acc_reg_val <= databus;
                    end
                    if (rw) begin
                        acc_mem_we   <= 1'b1;
                        acc_mem_addr <= mar;
                        acc_mem_data <= mdr;
                    end
                end
            end
        end
    end

    assign halted = (cap_state == CAP_HALTED);

    trace_fifo #(
        .W         (REC_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .din      (rec),
        .pop      (rd_ready),
        .dout     (rd_data),
        .valid    (rd_valid),
        .count    (count),
        .overflow (overflow)
    );

endmodule
